// File: rtl/rv_pkg.sv
// Shared RISC-V front-end constants.
//   WORD_SIZE  instruction width
//   NUM_WORDS  i_mem depth in words
//   ADDR_SIZE  PC width
//   NOP_INSTR  addi x0,x0,0 presented to decode when no instruction is valid
//   PC_STEP    PC increment per sequential fetch
package rv_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned NUM_WORDS = 1024;
  localparam int unsigned ADDR_SIZE = $clog2(NUM_WORDS);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with asynchronous head read.
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clear      synchronous flush; overrides push and pop
//   push       write push_data at the tail
//   pop        release the head entry (ignored when empty)
//   push_data  entry to write
//   head_data  current head entry (undefined content when empty)
//   count      number of valid entries, 0..DEPTH
//   empty      count == 0
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             pop_ok;

  // Explicit wrap so non-power-of-2 depths stay in range.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop_ok    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_next(wr_ptr);
      if (pop_ok) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  // The producer's credit scheme must never let a push meet a full queue.
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst)
    (push && !clear) |-> !full);

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: pairs each synchronous i_mem read with the PC that
// issued it, queues fetched instructions and hands them to decode with a
// valid/ready handshake. Throttles fetch through fetch_en and drops
// wrong-path work on a redirect.
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   fetch_pc     PC driven to i_mem this cycle
//   fetch_instr  i_mem data for the PC issued the previous cycle
//   flush        redirect taken this cycle
//   fetch_en     if_stage enable; 1 = PC advances and a read is issued
//   id_ready     decode accepts the head entry
//   id_valid     head entry valid
//   id_instr     head instruction, NOP when !id_valid
//   id_pc        head PC, 0 when !id_valid
module if_id_buffer #(
  parameter int unsigned WORD_SIZE = rv_pkg::WORD_SIZE,
  parameter int unsigned NUM_WORDS = rv_pkg::NUM_WORDS,
  parameter int unsigned ADDR_SIZE = $clog2(NUM_WORDS),
  parameter int unsigned DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE-1:0] fetch_pc,
  input  logic [WORD_SIZE-1:0] fetch_instr,
  input  logic                 flush,
  output logic                 fetch_en,
  input  logic                 id_ready,
  output logic                 id_valid,
  output logic [WORD_SIZE-1:0] id_instr,
  output logic [ADDR_SIZE-1:0] id_pc
);

  import rv_pkg::*;

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = WORD_SIZE + ADDR_SIZE;

  logic                 pend_valid;
  logic [ADDR_SIZE-1:0] pend_pc;
  logic                 issue;
  logic                 pop;
  logic                 push;
  logic [CNT_W-1:0]     count;
  logic                 empty;
  logic [ENTRY_W-1:0]   head;
  logic [CNT_W:0]       occupancy;

  assign id_valid = ~empty;
  assign pop      = id_valid & id_ready;
  assign push     = pend_valid & ~flush;
  assign issue    = fetch_en & ~flush;

  // Slots committed after this edge: queued + in flight - leaving.
  // pop implies count >= 1, so this never underflows.
  assign occupancy = {1'b0, count} + (CNT_W + 1)'(pend_valid) - (CNT_W + 1)'(pop);
  assign fetch_en  = flush | (occupancy < (CNT_W + 1)'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else if (issue) begin
      pend_valid <= 1'b1;
      pend_pc    <= fetch_pc;
    end else begin
      pend_valid <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .pop       (pop & ~flush),
    .push_data ({fetch_instr, pend_pc}),
    .head_data (head),
    .count     (count),
    .empty     (empty)
  );

  assign id_instr = id_valid ? head[ENTRY_W-1:ADDR_SIZE] : WORD_SIZE'(NOP_INSTR);
  assign id_pc    = id_valid ? head[ADDR_SIZE-1:0]       : '0;

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

  import rv_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [ADDR_SIZE-1:0] fetch_pc;
  logic [WORD_SIZE-1:0] fetch_instr;
  logic                 flush = 1'b0;
  logic                 fetch_en;
  logic                 id_ready = 1'b0;
  logic                 id_valid;
  logic [WORD_SIZE-1:0] id_instr;
  logic [ADDR_SIZE-1:0] id_pc;
  logic [ADDR_SIZE-1:0] branch_target = '0;
  logic [ADDR_SIZE-1:0] pc;

  int total = 0;
  int bad   = 0;
  logic [ADDR_SIZE-1:0] exp_q[$];

  always #5 clk = ~clk;

  if_id_buffer #(
    .WORD_SIZE (32),
    .NUM_WORDS (1024),
    .ADDR_SIZE (10),
    .DEPTH     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr),
    .flush       (flush),
    .fetch_en    (fetch_en),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  function automatic logic [31:0] imem(input logic [ADDR_SIZE-1:0] a);
    return 32'hC0DE_0000 | ((32'(a) * 32'd7) + 32'd1);
  endfunction

  // if_stage PC register and synchronous i_mem
  assign fetch_pc = pc;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= '0;
      fetch_instr <= '0;
    end else begin
      fetch_instr <= imem(pc);
      if (flush)         pc <= branch_target;
      else if (fetch_en) pc <= pc + ADDR_SIZE'(PC_STEP);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Scoreboard: issued PCs are queued, redirects discard everything
  // outstanding, handshakes pop and compare.
  task automatic sb_cycle();
    logic [ADDR_SIZE-1:0] e;
    if (id_valid && id_ready && !flush) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc %h required no valid output", id_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", 32'(id_pc), 32'(e));
        check("sb_instr", id_instr, imem(e));
      end
    end
    if (!id_valid) begin
      check("sb_idle_instr", id_instr, NOP_INSTR);
      check("sb_idle_pc", 32'(id_pc), 32'd0);
    end
    if (flush) exp_q.delete();
    if (fetch_en && !flush) exp_q.push_back(fetch_pc);
  endtask

  task automatic step(input logic rdy, input logic fl, input logic [ADDR_SIZE-1:0] tgt);
    @(negedge clk);
    id_ready      = rdy;
    flush         = fl;
    branch_target = tgt;
    #1;
    sb_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    id_ready = 1'b0;
    flush    = 1'b0;
    rst      = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_instr", id_instr, 32'h0000_0013);
    check("rst_pc", 32'(id_pc), 32'd0);
    check("rst_fetch_en", 32'(fetch_en), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  typedef struct {
    logic                 rst_first;
    logic                 rdy;
    logic                 fl;
    logic [ADDR_SIZE-1:0] tgt;
    logic                 ev;
    logic [ADDR_SIZE-1:0] epc;
    logic                 efe;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // backpressure from reset, then streaming
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 10'h0,  1'b0, 10'h0,  1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 10'h0,  1'b0, 10'h0,  1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 10'h0,  1'b1, 10'h0,  1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 10'h0,  1'b1, 10'h0,  1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 10'h0,  1'b1, 10'h0,  1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 10'h0,  1'b1, 10'h0,  1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 10'h0,  1'b1, 10'h4,  1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 10'h0,  1'b1, 10'h8,  1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 10'h0,  1'b1, 10'hC,  1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 10'h0,  1'b1, 10'h10, 1'b1};
    // fill, then flush with id_ready=1 while valid, redirect to 0x40
    tbl[10] = '{1'b1, 1'b0, 1'b0, 10'h0,  1'b0, 10'h0,  1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 10'h0,  1'b0, 10'h0,  1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 10'h0,  1'b1, 10'h0,  1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 10'h0,  1'b1, 10'h0,  1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 10'h40, 1'b1, 10'h0,  1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 10'h0,  1'b0, 10'h0,  1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 10'h0,  1'b0, 10'h0,  1'b1};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 10'h0,  1'b1, 10'h40, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 10'h0,  1'b1, 10'h44, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 10'h0,  1'b1, 10'h48, 1'b1};

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].rst_first) do_reset();
      step(tbl[i].rdy, tbl[i].fl, tbl[i].tgt);
      check($sformatf("vec%0d_valid", i), 32'(id_valid), 32'(tbl[i].ev));
      check($sformatf("vec%0d_fetch_en", i), 32'(fetch_en), 32'(tbl[i].efe));
      if (tbl[i].ev) begin
        check($sformatf("vec%0d_pc", i), 32'(id_pc), 32'(tbl[i].epc));
        check($sformatf("vec%0d_instr", i), id_instr, imem(tbl[i].epc));
      end else begin
        check($sformatf("vec%0d_pc", i), 32'(id_pc), 32'd0);
        check($sformatf("vec%0d_instr", i), id_instr, NOP_INSTR);
      end
    end

    // random ready/flush traffic, scoreboard only
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           ADDR_SIZE'({$urandom_range(0, 255), 2'b00}));
    end

    // async reset between edges with two entries queued
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    check("pre_async_valid", 32'(id_valid), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("async_valid", 32'(id_valid), 32'd0);
    check("async_instr", id_instr, 32'h0000_0013);
    check("async_pc", 32'(id_pc), 32'd0);
    check("async_fetch_en", 32'(fetch_en), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    check("post_async_pc", 32'(id_pc), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required test completion");
    $fatal(1, "timeout");
  end

endmodule
